uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Serial receiver for the control UART: it recovers one 11-bit frame from the `Rx` pin and presents it as a 9-bit parallel frame with a one-cycle valid strobe. The frame format is start bit, 8 data bits LSB first, an even-parity bit, and a stop bit. The block sits directly upstream of the frame decoder / debug register path, which consumes the `{parity, data}` word and displays it on the seven-segment debug view. Error flags let the consumer drop corrupted frames.

## Interface
- `CLKS_PER_BIT`, 32: clock cycles per UART bit. Even, ≥ 4. The default gives 320 ns per bit at a 100 MHz clock.
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset. Synchronous and active-high.
- `rx`  in  1: asynchronous serial line. Idles high.
- `frame`  out  9: last good-stop frame, `{parity_bit, data[7:0]}`. Held until the next accepted frame.
- `frame_valid`  out  1: one-cycle pulse; `frame` and `parity_err` are new in that cycle.
- `parity_err`  out  1: high with `frame_valid` when `^data ^ parity_bit` = 1. Held with `frame`.
- `framing_err`  out  1: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **Bit counter:** `cnt` counts 0..CLKS_PER_BIT-1. `bit_idx` is 3 bits.
- **IDLE:** when `rx_s`=0, go to START with `cnt`=0.
- **START:** on the edge where `cnt`=CLKS_PER_BIT/2-1 (mid start bit):
  - if `rx_s`=0, go to DATA with `cnt`=0 and `bit_idx`=0;
  - otherwise treat it as a glitch and return to IDLE with no output.
- **DATA:** on each edge where `cnt`=CLKS_PER_BIT-1, shift `rx_s` into `data[bit_idx]` and reset `cnt`. After `bit_idx`=7 is sampled, go to PARITY.
- **PARITY:** sample into `parity_bit` at `cnt`=CLKS_PER_BIT-1, then go to STOP.
- **STOP:** sample at `cnt`=CLKS_PER_BIT-1.
  - If 1: register `frame`, `parity_err` and `frame_valid`=1, then go to IDLE.
  - If 0: pulse `framing_err`, leave `frame` unchanged, then go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s`=1, then go to IDLE. A line held low produces exactly one `framing_err` and does not retrigger.
- **Parity errors:** a frame with bad parity is still delivered, with `parity_err`=1. Dropping it is the consumer's choice.

## Timing
- **Reset values:** `frame`=0, `frame_valid`=0, `parity_err`=0, `framing_err`=0. State is IDLE, `cnt`=0, synchronizer flops are 1.
- **Reset precedence:** reset asserted mid-frame aborts the frame with no valid or error pulse. Reset wins over every other event in the same cycle.
- **Latency:** let edge e0 be the first edge that captures `rx`=0 into sync flop 1. The stop bit is sampled at edge e0+2+CLKS_PER_BIT/2+10·CLKS_PER_BIT. `frame_valid` (or `framing_err`) is high for the cycle after that edge. With the default parameter this is edge e0+338.
- **Pulse width:** `frame_valid` and `framing_err` are never high together and never high for more than 1 cycle.
- **Back-to-back frames:** a start bit beginning right after the stop mid-sample is accepted. Only half a stop bit is consumed, so back-to-back frames at the nominal rate are received without loss.
- **Bit-time tolerance:** sampling is at mid-bit, so a ±1 cycle jitter per bit boundary is tolerated at the default CLKS_PER_BIT.
- **No handshake:** there is no backpressure. The consumer must take `frame` on the `frame_valid` cycle or read the held value later.

## Structure
- **Shared package `uart_pkg`:**
  - state enum (`UART_IDLE`..`UART_WAIT_IDLE`);
  - `UART_FRAME_W`=9;
  - `UART_CLKS_PER_BIT_DEFAULT`=32;
  - `UART_PARITY_EVEN`=1'b0 (the parity-bit value for even parity of an even-weight byte).
  
  The frame decoder and the testbenches use the same package.
- **Sub-module `sync_2ff`:** a generic 2-flop synchronizer with a reset-value parameter, reused for the `BTNC` and switch inputs.
- **Remaining RTL:** the FSM, counters and output registers live in `uart_rx_frame`.

## Test plan
- **Good frame, even-weight byte:** reset 30 cycles with `rx`=1, then send data 0x21, parity 0, stop 1 at 32 cycles/bit. Expect exactly one `frame_valid`, `frame`=9'h021, `parity_err`=0, at edge e0+338.
- **Good frame, odd-weight byte:** send 0x2F, parity 1, immediately followed by 0x21, parity 0. Expect `frame`=9'h12F then 9'h021, `parity_err`=0 both times, with no frame lost.
- **Parity error:** send 0x21 with parity bit 1. Expect `frame_valid` with `frame`=9'h121 and `parity_err`=1.
- **Start glitch and framing error:** drive a 10-cycle low glitch on an idle line; expect no outputs and the FSM back in IDLE. Then send 0x55 with stop bit 0, holding `rx` low 400 more cycles. Expect exactly one `framing_err`, `frame` unchanged, and no retrigger until `rx` returns high.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4. Expect no pulses and all outputs 0. A following 0x21 frame is received correctly.
- **Line low out of reset:** hold `rx`=0 through reset and for 600 cycles after. Expect one `framing_err`, then correct reception of 0x21 once the line idles high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP,
    UART_WAIT_IDLE
  } uart_state_e;

  localparam int   UART_FRAME_W              = 9;
  localparam int   UART_CLKS_PER_BIT_DEFAULT = 32;
  localparam logic UART_PARITY_EVEN          = 1'b0;

  // Even parity: the parity bit must equal the XOR of the data bits.
  function automatic logic uart_parity_err(input logic [7:0] data, input logic par);
    return ((^data) ^ par) != UART_PARITY_EVEN;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input; 2-cycle latency, no backpressure.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx_frame.sv
// 8E1 UART receiver: one frame out 2+CLKS_PER_BIT/2+10*CLKS_PER_BIT edges after start capture,
// plus one register stage. No backpressure: frame_valid is a single-cycle strobe, frame is held.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx,
  output logic [UART_FRAME_W-1:0] frame,
  output logic                    frame_valid,
  output logic                    parity_err,
  output logic                    framing_err
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_state_e             state_d, state_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic [2:0]              bit_idx_d, bit_idx_q;
  logic [7:0]              data_d, data_q;
  logic                    parity_d, parity_q;
  logic [UART_FRAME_W-1:0] frame_d, frame_q;
  logic                    perr_d, perr_q;
  logic                    fv_d, fv_q;
  logic                    fe_d, fe_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    parity_d  = parity_q;
    frame_d   = frame_q;
    perr_d    = perr_q;
    fv_d      = 1'b0;
    fe_d      = 1'b0;

    unique case (state_q)
      UART_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = UART_START;
      end
      UART_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A start bit that is already gone at mid-bit was a glitch.
          state_d   = rx_s ? UART_IDLE : UART_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UART_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d             = '0;
          data_d[bit_idx_q] = rx_s;
          bit_idx_d         = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = UART_PARITY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UART_PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          parity_d = rx_s;
          state_d  = UART_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UART_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
          if (rx_s) begin
            frame_d = {parity_q, data_q};
            perr_d  = uart_parity_err(data_q, parity_q);
            fv_d    = 1'b1;
            state_d = UART_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = UART_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UART_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = UART_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = UART_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UART_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      frame_q   <= '0;
      perr_q    <= 1'b0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      frame_q   <= frame_d;
      perr_q    <= perr_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign parity_err  = perr_q;
  assign framing_err = fe_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed vector table, multi-cycle corner sequences, random frames vs a frame-level model.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int CPB      = 32;
  localparam int LAT      = 2 + CPB / 2 + 10 * CPB;
  localparam int EV_VALID = 1;
  localparam int EV_FERR  = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    rx  = 1'b1;
  logic [UART_FRAME_W-1:0] frame;
  logic                    frame_valid;
  logic                    parity_err;
  logic                    framing_err;

  uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .frame       (frame),
    .frame_valid (frame_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [8:0] frm;
    logic       perr;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stp;
    int         hold_low;
    int         kind;
    logic [8:0] exp_frame;
    logic       exp_perr;
  } vec_t;

  ev_t mon_q[$];
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  logic prev_fv = 1'b0;
  logic prev_fe = 1'b0;

  // Observe every output pulse on the falling edge; also police pulse width/exclusivity.
  always @(negedge clk) begin
    if (frame_valid || framing_err) begin
      checks++;
      if ((frame_valid && framing_err) || (frame_valid && prev_fv) || (framing_err && prev_fe)) begin
        errors++;
        $display("FAIL pulse_shape at cyc %0d: got fv=%b fe=%b prev_fv=%b prev_fe=%b, required single exclusive pulse",
                 cyc, frame_valid, framing_err, prev_fv, prev_fe);
      end
      mon_q.push_back('{kind: (frame_valid ? EV_VALID : EV_FERR), frm: frame, perr: parity_err, cyc: cyc});
    end
    prev_fv = frame_valid;
    prev_fe = framing_err;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [8:0] frm, input logic perr, input int c);
    exp_q.push_back('{kind: kind, frm: frm, perr: perr, cyc: c});
  endtask

  task automatic check_events(input string name);
    int n;
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s event_count: got %0d, required %0d", name, mon_q.size(), exp_q.size());
    end
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mon_q[i].kind != exp_q[i].kind || mon_q[i].frm !== exp_q[i].frm ||
          mon_q[i].perr !== exp_q[i].perr || mon_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL %s event %0d: got kind=%0d frame=%h perr=%b cyc=%0d, required kind=%0d frame=%h perr=%b cyc=%0d",
                 name, i, mon_q[i].kind, mon_q[i].frm, mon_q[i].perr, mon_q[i].cyc,
                 exp_q[i].kind, exp_q[i].frm, exp_q[i].perr, exp_q[i].cyc);
      end
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  // Called on a falling edge; e0 is the edge number that first captures the start bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int nbits, input bit jit, output int e0);
    logic [10:0] bits;
    int          len;
    bits = {s, p, d, 1'b0};
    e0   = cyc + 1;
    for (int i = 0; i < nbits; i++) begin
      rx  = bits[i];
      len = jit ? (CPB - 1 + int'($urandom_range(0, 2))) : CPB;
      repeat (len) @(negedge clk);
    end
  endtask

  vec_t       tbl[6];
  int         e0;
  logic [8:0] last_frame;
  logic       last_perr;

  initial begin
    tbl[0] = '{8'h21, 1'b0, 1'b1, 0,   EV_VALID, 9'h021, 1'b0};
    tbl[1] = '{8'h2F, 1'b1, 1'b1, 0,   EV_VALID, 9'h12F, 1'b0};
    tbl[2] = '{8'h21, 1'b0, 1'b1, 0,   EV_VALID, 9'h021, 1'b0};
    tbl[3] = '{8'h21, 1'b1, 1'b1, 0,   EV_VALID, 9'h121, 1'b1};
    tbl[4] = '{8'h55, 1'b0, 1'b0, 400, EV_FERR,  9'h121, 1'b1};
    tbl[5] = '{8'h21, 1'b0, 1'b1, 0,   EV_VALID, 9'h021, 1'b0};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (30) @(negedge clk);
    check_val("reset_frame", 32'(frame), 32'h0);
    check_val("reset_frame_valid", 32'(frame_valid), 32'h0);
    check_val("reset_parity_err", 32'(parity_err), 32'h0);
    check_val("reset_framing_err", 32'(framing_err), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Directed vectors, sent back to back unless the entry holds the line low.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stp, 11, 1'b0, e0);
      push_exp(tbl[i].kind, tbl[i].exp_frame, tbl[i].exp_perr, e0 + LAT);
      if (tbl[i].hold_low > 0) begin
        rx = 1'b0;
        repeat (tbl[i].hold_low) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
      end
    end
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check_events("table");
    check_val("table_held_frame", 32'(frame), 32'h021);

    // Short low glitch on an idle line.
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check_val("glitch_state_idle", 32'(dut.state_q), 32'(UART_IDLE));
    check_events("glitch");
    check_val("glitch_held_frame", 32'(frame), 32'h021);

    // Reset in the middle of data bit 4; the line then idles.
    send_frame(8'h21, 1'b0, 1'b1, 5, 1'b0, e0);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (400) @(negedge clk);
    check_events("reset_mid_frame");
    check_val("rst_mid_frame", 32'(frame), 32'h0);
    check_val("rst_mid_parity_err", 32'(parity_err), 32'h0);
    send_frame(8'h21, 1'b0, 1'b1, 11, 1'b0, e0);
    push_exp(EV_VALID, 9'h021, 1'b0, e0 + LAT);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check_events("after_reset_frame");

    // Line held low through and after reset.
    rst = 1'b1;
    rx  = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    e0  = cyc + 1;
    push_exp(EV_FERR, 9'h000, 1'b0, e0 + LAT);
    repeat (600) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h21, 1'b0, 1'b1, 11, 1'b0, e0);
    push_exp(EV_VALID, 9'h021, 1'b0, e0 + LAT);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check_events("line_low_reset");

    // Random frames with per-bit jitter, judged by a frame-level model.
    last_frame = 9'h021;
    last_perr  = 1'b0;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       p;
      logic       s;
      int         gap;
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, p, s, 11, 1'b1, e0);
      if (s) begin
        last_frame = {p, d};
        last_perr  = ($countones({p, d}) % 2) != 0;
        push_exp(EV_VALID, last_frame, last_perr, e0 + LAT);
      end else begin
        push_exp(EV_FERR, last_frame, last_perr, e0 + LAT);
      end
      rx  = 1'b1;
      gap = s ? int'($urandom_range(0, 2)) * int'($urandom_range(0, 20)) : CPB + int'($urandom_range(0, 40));
      repeat (gap) @(negedge clk);
    end
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check_events("random");
    check_val("random_held_frame", 32'(frame), 32'(last_frame));
    check_val("random_held_perr", 32'(parity_err), 32'(last_perr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
